// File: rtl/tank_sensor_model.sv
// Behavioural tank model: a prescaled level integrator with saturation flags and a
// hysteretic DRY/LOW/HIGH wet-sensor FSM. Define TANK_FAULT_INJ_EN to add the fault_top input.
module tank_sensor_model #(
  parameter int unsigned LEVEL_MAX  = 255,
  parameter int unsigned BOT_THRESH = 64,
  parameter int unsigned TOP_THRESH = 192,
  parameter int unsigned HYST       = 4,
  parameter int unsigned RATE_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fill,
  input  logic       drain,
  input  logic       load_en,
  input  logic [7:0] load_val,
`ifdef TANK_FAULT_INJ_EN
  input  logic       fault_top,
`endif
  output logic       Bot,
  output logic       Top,
  output logic [7:0] level,
  output logic       ovf,
  output logic       unf
);

  localparam int unsigned LW = 8;
  localparam logic [LW-1:0] L_MAX     = LW'(LEVEL_MAX);
  localparam logic [LW-1:0] L_BOT_ON  = LW'(BOT_THRESH);
  localparam logic [LW-1:0] L_TOP_ON  = LW'(TOP_THRESH);
  localparam logic [LW-1:0] L_BOT_OFF = LW'(BOT_THRESH - HYST);
  localparam logic [LW-1:0] L_TOP_OFF = LW'(TOP_THRESH - HYST);
  localparam logic [LW-1:0] P_LAST    = LW'(RATE_DIV - 1);

  // Bad threshold/rate combinations would give overlapping bands or an unusable prescaler.
  if (BOT_THRESH < HYST || TOP_THRESH <= BOT_THRESH + HYST ||
      RATE_DIV < 2 || RATE_DIV > 255 || LEVEL_MAX > 255) begin : g_bad_params
    $error("tank_sensor_model: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_DRY  = 2'b00,
    S_LOW  = 2'b01,
    S_HIGH = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   r_presc;
  logic            r_ovf;
  logic            r_unf;
  logic            r_fault;
  logic            w_tick;
  logic            w_up;
  logic            w_dn;

  assign w_tick = (r_presc == P_LAST);
  assign w_up   = fill & ~drain;
  assign w_dn   = drain & ~fill;

  // Level integrator; a load preempts the tick and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_presc <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (load_en) begin
      r_level <= (load_val > L_MAX) ? L_MAX : load_val;
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + LW'(1);
      if (w_tick && w_up) begin
        if (r_level == L_MAX) r_ovf   <= 1'b1;
        else                  r_level <= r_level + LW'(1);
      end else if (w_tick && w_dn) begin
        if (r_level == '0)    r_unf   <= 1'b1;
        else                  r_level <= r_level - LW'(1);
      end
    end
  end

  // Sensor state register, plus the fault strobe aligned to the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DRY;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nx;
`ifdef TANK_FAULT_INJ_EN
      r_fault <= fault_top;
`else
      r_fault <= 1'b0;
`endif
    end
  end

  // Next state from the registered level; bands may be crossed in one step after a load.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_DRY: begin
        if (r_level >= L_TOP_ON)      w_state_nx = S_HIGH;
        else if (r_level >= L_BOT_ON) w_state_nx = S_LOW;
      end
      S_LOW: begin
        if (r_level >= L_TOP_ON)      w_state_nx = S_HIGH;
        else if (r_level < L_BOT_OFF) w_state_nx = S_DRY;
      end
      S_HIGH: begin
        if (r_level < L_BOT_OFF)      w_state_nx = S_DRY;
        else if (r_level < L_TOP_OFF) w_state_nx = S_LOW;
      end
      default:                        w_state_nx = S_DRY;
    endcase
  end

  // Sensor outputs decoded from the state register only.
  always_comb begin
    Bot = 1'b0;
    Top = 1'b0;
    case (r_state)
      S_LOW:   Bot = 1'b1;
      S_HIGH: begin
        Bot = 1'b1;
        Top = 1'b1;
      end
      default: ;
    endcase
    Top = Top | r_fault;
  end

  assign level = r_level;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_tank_sensor_model.sv
// Randomised self-checking bench for tank_sensor_model against a cycle-level behavioural model.
module tb_tank_sensor_model;

  localparam int LMAX = 255, BOT = 64, TOPT = 192, HY = 4, RD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fill, drain, load_en, fault_top;
  logic [7:0] load_val;
  logic       Bot, Top, ovf, unf;
  logic [7:0] level;

  int tests = 0;
  int fails = 0;

  int m_level, m_cyc;
  bit m_bot, m_top, m_ovf, m_unf, m_fault;

  tank_sensor_model #(
    .LEVEL_MAX(LMAX), .BOT_THRESH(BOT), .TOP_THRESH(TOPT), .HYST(HY), .RATE_DIV(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fill(fill), .drain(drain),
    .load_en(load_en), .load_val(load_val),
`ifdef TANK_FAULT_INJ_EN
    .fault_top(fault_top),
`endif
    .Bot(Bot), .Top(Top), .level(level), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_level = 0; m_cyc = 0;
    m_bot = 0; m_top = 0; m_ovf = 0; m_unf = 0; m_fault = 0;
  endtask

  // Apply inputs, advance one clock, update the model, and settle 1ns past the edge.
  task automatic step(input bit f, input bit d, input bit le, input int lv);
    bit nb, nt;
    fill = f; drain = d; load_en = le; load_val = 8'(lv);
    @(posedge clk);
    nb = m_bot ? (m_level >= BOT - HY) : (m_level >= BOT);
    nt = m_top ? (m_level >= TOPT - HY) : (m_level >= TOPT);
    m_bot = nb; m_top = nt;
`ifdef TANK_FAULT_INJ_EN
    m_fault = fault_top;
`endif
    if (le) begin
      m_level = (lv > LMAX) ? LMAX : lv;
      m_cyc = 0;
    end else begin
      if (m_cyc % RD == RD - 1) begin
        if (f && !d) begin
          if (m_level == LMAX) m_ovf = 1; else m_level++;
        end else if (d && !f) begin
          if (m_level == 0) m_unf = 1; else m_level--;
        end
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fill = 0; drain = 0; load_en = 0; load_val = '0; fault_top = 0;
    model_reset();
    #12;
    tests++;
    if ({level, Bot, Top, ovf, unf} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got level=%0d Bot=%b Top=%b ovf=%b unf=%b, want all 0",
               level, Bot, Top, ovf, unf);
    end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_fill_256();
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({level, Bot, Top, ovf, unf} !== {8'(m_level), m_bot, m_top | m_fault, m_ovf, m_unf}) begin
        fails++;
        $display("FAIL fill_model cyc %0d: got lvl=%0d B=%b T=%b, want lvl=%0d B=%b T=%b",
                 i, level, Bot, Top, m_level, m_bot, m_top);
      end
    end
    tests++;
    if (level !== 8'd64 || Bot !== 1'b0) begin
      fails++;
      $display("FAIL fill_256_level: got level=%0d Bot=%b, want 64 Bot=0", level, Bot);
    end
    step(0, 0, 0, 0);
    tests++;
    if (Bot !== 1'b1 || Top !== 1'b0) begin
      fails++;
      $display("FAIL fill_256_bot: got Bot=%b Top=%b, want 1 0", Bot, Top);
    end
  endtask

  task automatic test_load_hyst();
    bit hit = 0;
    step(0, 0, 1, 200);
    tests++;
    if (level !== 8'd200) begin
      fails++;
      $display("FAIL load_200: got level=%0d want 200", level);
    end
    step(0, 0, 0, 0);
    tests++;
    if (Bot !== 1'b1 || Top !== 1'b1) begin
      fails++;
      $display("FAIL load_200_sensors: got Bot=%b Top=%b want 1 1", Bot, Top);
    end
    for (int i = 0; i < 100 && !hit; i++) begin
      step(0, 1, 0, 0);
      tests++;
      if ({level, Bot, Top} !== {8'(m_level), m_bot, m_top | m_fault}) begin
        fails++;
        $display("FAIL drain_model: got lvl=%0d B=%b T=%b want lvl=%0d B=%b T=%b",
                 level, Bot, Top, m_level, m_bot, m_top);
      end
      hit = (m_level == 187);
    end
    tests++;
    if (!hit || Top !== 1'b1) begin
      fails++;
      $display("FAIL top_held_at_188: got Top=%b level=%0d want Top=1 level=187", Top, level);
    end
    step(0, 0, 0, 0);
    tests++;
    if (Top !== 1'b0 || Bot !== 1'b1) begin
      fails++;
      $display("FAIL top_release_187: got Bot=%b Top=%b want 1 0", Bot, Top);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 1, 255);
    for (int i = 0; i < RD; i++) step(1, 0, 0, 0);
    tests++;
    if (level !== 8'd255 || ovf !== 1'b1 || unf !== 1'b0) begin
      fails++;
      $display("FAIL overflow: got level=%0d ovf=%b unf=%b want 255 1 0", level, ovf, unf);
    end
    step(0, 0, 1, 0);
    for (int i = 0; i < RD; i++) step(0, 1, 0, 0);
    tests++;
    if (level !== 8'd0 || unf !== 1'b1 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL underflow: got level=%0d ovf=%b unf=%b want 0 1 1", level, ovf, unf);
    end
  endtask

  task automatic test_both_cmds();
    step(0, 0, 1, 100);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    tests++;
    if (level !== 8'd100 || Bot !== 1'b1 || Top !== 1'b0) begin
      fails++;
      $display("FAIL fill_and_drain: got level=%0d Bot=%b Top=%b want 100 1 0", level, Bot, Top);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 68);
    while (m_level < 70) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({level, Bot, Top, ovf, unf} !== 12'h000) begin
      fails++;
      $display("FAIL async_reset: got level=%0d Bot=%b Top=%b ovf=%b unf=%b want all 0",
               level, Bot, Top, ovf, unf);
    end
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2 * RD; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if (level !== 8'(m_level)) begin
        fails++;
        $display("FAIL resume_after_reset cyc %0d: got level=%0d want %0d", i, level, m_level);
      end
    end
  endtask

  task automatic test_random();
    bit dir = 1;
    for (int i = 0; i < 3000; i++) begin
      bit f, d, le;
      int lv;
      if ($urandom_range(0, 99) < 3) dir = ~dir;
      f  = dir ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
      d  = dir ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 8);
      le = ($urandom_range(0, 199) == 0);
      lv = $urandom_range(0, 255);
      step(f, d, le, lv);
      tests++;
      if ({level, Bot, Top, ovf, unf} !== {8'(m_level), m_bot, m_top | m_fault, m_ovf, m_unf}) begin
        fails++;
        $display("FAIL random cyc %0d: got lvl=%0d B=%b T=%b o=%b u=%b want lvl=%0d B=%b T=%b o=%b u=%b",
                 i, level, Bot, Top, ovf, unf, m_level, m_bot, m_top | m_fault, m_ovf, m_unf);
      end
    end
  endtask

`ifdef TANK_FAULT_INJ_EN
  task automatic test_fault();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    fault_top = 1'b1;
    step(0, 0, 0, 0);
    tests++;
    if (Bot !== 1'b0 || Top !== 1'b1 || level !== 8'd0) begin
      fails++;
      $display("FAIL fault_on: got Bot=%b Top=%b level=%0d want 0 1 0", Bot, Top, level);
    end
    fault_top = 1'b0;
    step(0, 0, 0, 0);
    tests++;
    if (Top !== 1'b0) begin
      fails++;
      $display("FAIL fault_off: got Top=%b want 0", Top);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_256();
    test_load_hyst();
    test_saturate();
    test_both_cmds();
    test_async_reset();
    test_random();
`ifdef TANK_FAULT_INJ_EN
    test_fault();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
